// File: rtl/gtech_and3_reduce_pipe_pkg.sv
// Shared sizing helpers for the pipelined AND3 reduction tree.
// Levels, per-level node counts and offsets into the flattened level bus.
package gtech_reduce_pkg;

    localparam logic PAD_AND   = 1'b1;
    localparam int   MIN_WIDTH = 2;
    localparam int   MAX_WIDTH = 243;

    // Smallest L with 3**L >= n, i.e. the number of AND3 levels needed.
    function automatic int clog3(input int n);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < n) begin
            span   = span * 3;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Node count at level k; level 0 is the raw operand width.
    function automatic int level_width(input int width, input int k);
        int n;
        n = width;
        for (int unsigned i = 0; i < unsigned'(k); i++) begin
            n = (n + 2) / 3;
        end
        return n;
    endfunction

    function automatic int level_offset(input int width, input int k);
        int off;
        off = 0;
        for (int unsigned i = 0; i < unsigned'(k); i++) begin
            off = off + level_width(width, int'(i));
        end
        return off;
    endfunction

endpackage

// File: rtl/gtech_and3_reduce_pipe_stage.sv
// One reduction level: ceil(N_IN/3) AND3 nodes followed by a data/valid
// register with a pass-through ready (ready = ~valid | downstream ready).
module gtech_and3_pipe_stage
    import gtech_reduce_pkg::*;
#(
    parameter int N_IN = 9
) (
    input  logic                    CP,
    input  logic                    CD,
    input  logic [N_IN-1:0]         i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [(N_IN+2)/3-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int N_OUT = (N_IN + 2) / 3;

    logic [3*N_OUT-1:0] w_padded;
    logic [N_OUT-1:0]   w_and;
    logic [N_OUT-1:0]   r_data;
    logic               r_valid;

    // Missing inputs of the last node are tied to the AND identity.
    always_comb begin
        w_padded             = {(3*N_OUT){PAD_AND}};
        w_padded[N_IN-1:0]   = i_data;
    end

    always_comb begin
        w_and = '0;
        for (int unsigned j = 0; j < unsigned'(N_OUT); j++) begin
            w_and[j] = &w_padded[3*j +: 3];
        end
    end

    assign o_ready = ~r_valid | i_ready;

    // Data only loads with a valid word so junk on idle inputs never enters.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_and;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/gtech_and3_reduce_pipe.sv
// Pipelined wide AND reduction: LEVELS registered AND3 levels with a
// valid/ready handshake between each, one AND3 delay per cycle.
module gtech_and3_reduce_pipe
    import gtech_reduce_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             CP,
    input  logic             CD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             Z,
    output logic             Z_VALID,
    input  logic             Z_READY
);

    localparam int LEVELS = clog3(WIDTH);
    localparam int BUS_W  = level_offset(WIDTH, LEVELS + 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "gtech_and3_reduce_pipe: WIDTH %0d outside 2..243", WIDTH);
    end

    // All level outputs share one flat bus; level k sits at level_offset(k).
    logic [BUS_W-1:0] w_data;
    logic [LEVELS:0]  w_valid;

    assign w_data[WIDTH-1:0] = DIN;
    assign w_valid[0]        = DIN_VALID;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int NI   = level_width(WIDTH, k - 1);
        localparam int NO   = level_width(WIDTH, k);
        localparam int OFFI = level_offset(WIDTH, k - 1);
        localparam int OFFO = level_offset(WIDTH, k);

        logic w_rdy;
        logic w_rdy_out;

        // Ready chain kept per level so the combinational path is not one vector.
        if (k == LEVELS) begin : g_tail
            assign w_rdy_out = Z_READY;
        end else begin : g_link
            assign w_rdy_out = g_lvl[k+1].w_rdy;
        end

        gtech_and3_pipe_stage #(
            .N_IN (NI)
        ) u_stage (
            .CP      (CP),
            .CD      (CD),
            .i_data  (w_data[OFFI +: NI]),
            .i_valid (w_valid[k-1]),
            .o_ready (w_rdy),
            .o_data  (w_data[OFFO +: NO]),
            .o_valid (w_valid[k]),
            .i_ready (w_rdy_out)
        );
    end

    assign DIN_READY = g_lvl[1].w_rdy;
    assign Z         = w_data[BUS_W-1];
    assign Z_VALID   = w_valid[LEVELS];

endmodule

// File: tb/tb_gtech_and3_reduce_pipe.sv
// Scoreboard bench: WIDTH=9 (2 levels) and WIDTH=10 (3 levels) instances
// driven side by side; expected Z is "word is all ones" per accepted word.
module tb_gtech_and3_reduce_pipe;

    logic CP = 1'b0;
    logic CD = 1'b0;

    logic [8:0] din9;
    logic       v9, rdy9, z9, zv9, zr9;
    logic [9:0] din10;
    logic       v10, rdy10, z10, zv10, zr10;

    always #5 CP = ~CP;

    gtech_and3_reduce_pipe #(.WIDTH(9)) u_dut9 (
        .CP(CP), .CD(CD), .DIN(din9), .DIN_VALID(v9), .DIN_READY(rdy9),
        .Z(z9), .Z_VALID(zv9), .Z_READY(zr9)
    );

    gtech_and3_reduce_pipe #(.WIDTH(10)) u_dut10 (
        .CP(CP), .CD(CD), .DIN(din10), .DIN_VALID(v10), .DIN_READY(rdy10),
        .Z(z10), .Z_VALID(zv10), .Z_READY(zr10)
    );

    typedef struct {
        logic z;
        int   cyc;
    } exp_t;

    exp_t q9[$];
    exp_t q10[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;

    always @(posedge CP) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic ref9(input logic [8:0] d);
        return d == 9'h1FF;
    endfunction

    function automatic logic ref10(input logic [9:0] d);
        return d == 10'h3FF;
    endfunction

    // Monitor / scoreboard, WIDTH=9
    logic prev_stall9 = 1'b0;
    logic prev_z9     = 1'b0;
    always @(negedge CP) begin
        if (!CD) begin
            prev_stall9 = 1'b0;
        end else begin
            if (prev_stall9) begin
                chk("w9_hold_valid", zv9, 1);
                chk("w9_hold_z", z9, prev_z9);
            end
            if (zv9 && zr9) begin
                chk("w9_output_expected", int'(q9.size() != 0), 1);
                if (q9.size() != 0) begin
                    exp_t e;
                    e = q9.pop_front();
                    chk("w9_z", z9, e.z);
                    if (lat_chk) chk("w9_latency", cyc - e.cyc, 2);
                end
            end
            if (v9 && rdy9) q9.push_back('{ref9(din9), cyc});
            prev_stall9 = zv9 && !zr9;
            prev_z9     = z9;
        end
    end

    // Monitor / scoreboard, WIDTH=10
    logic prev_stall10 = 1'b0;
    logic prev_z10     = 1'b0;
    always @(negedge CP) begin
        if (!CD) begin
            prev_stall10 = 1'b0;
        end else begin
            if (prev_stall10) begin
                chk("w10_hold_valid", zv10, 1);
                chk("w10_hold_z", z10, prev_z10);
            end
            if (zv10 && zr10) begin
                chk("w10_output_expected", int'(q10.size() != 0), 1);
                if (q10.size() != 0) begin
                    exp_t e;
                    e = q10.pop_front();
                    chk("w10_z", z10, e.z);
                    if (lat_chk) chk("w10_latency", cyc - e.cyc, 3);
                end
            end
            if (v10 && rdy10) q10.push_back('{ref10(din10), cyc});
            prev_stall10 = zv10 && !zr10;
            prev_z10     = z10;
        end
    end

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [8:0] d9, input logic [9:0] d10, input bit zr);
        v9    = v;
        v10   = v;
        din9  = d9;
        din10 = d10;
        zr9   = zr;
        zr10  = zr;
    endtask

    function automatic logic [8:0] rnd9();
        logic [8:0] d;
        case ($urandom % 3)
            0:       d = 9'h1FF;
            1:       d = 9'h1FF ^ (9'd1 << $urandom_range(8, 0));
            default: d = 9'($urandom);
        endcase
        return d;
    endfunction

    function automatic logic [9:0] rnd10();
        logic [9:0] d;
        case ($urandom % 3)
            0:       d = 10'h3FF;
            1:       d = 10'h3FF ^ (10'd1 << $urandom_range(9, 0));
            default: d = 10'($urandom);
        endcase
        return d;
    endfunction

    logic [8:0] dir9  [6] = '{9'h1FF, 9'h1FE, 9'h1FF, 9'h0FF, 9'h1FF, 9'h1BF};
    logic [9:0] dir10 [6] = '{10'h3FF, 10'h1FF, 10'h3FF, 10'h2FF, 10'h3FF, 10'h3FE};

    initial begin
        int acc9;
        int acc10;

        // Reset with random activity on the inputs
        CD = 1'b0;
        set_in(1'b1, rnd9(), rnd10(), 1'b1);
        repeat (4) begin
            tick();
            set_in(1'($urandom), rnd9(), rnd10(), 1'($urandom));
            @(negedge CP);
            chk("reset_z9", z9, 0);
            chk("reset_zv9", zv9, 0);
            chk("reset_z10", z10, 0);
            chk("reset_zv10", zv10, 0);
        end
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        CD = 1'b1;
        @(negedge CP);
        chk("din_ready_after_reset9", rdy9, 1);
        chk("din_ready_after_reset10", rdy10, 1);

        // Single words, back-to-back stream and padding, latency enforced
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            set_in(1'b1, dir9[i], dir10[i], 1'b1);
        end
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        repeat (6) tick();
        lat_chk = 1'b0;

        // Backpressure: consumer stalls while words keep arriving
        acc9  = 0;
        acc10 = 0;
        repeat (4) begin
            tick();
            set_in(1'b1, rnd9(), rnd10(), 1'b0);
            @(negedge CP);
            if (rdy9)  acc9++;
            if (rdy10) acc10++;
        end
        chk("bp_accepted9", acc9, 2);
        chk("bp_accepted10", acc10, 3);
        chk("bp_din_ready9", rdy9, 0);
        chk("bp_din_ready10", rdy10, 0);
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        repeat (6) tick();
        chk("bp_drained9", q9.size(), 0);
        chk("bp_drained10", q10.size(), 0);

        // Mid-stream reset with two words in flight
        set_in(1'b1, 9'h1FF, 10'h3FF, 1'b1);
        tick();
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        #2;
        chk("pre_reset_zv9", zv9, 1);
        CD = 1'b0;
        #1;
        chk("async_drop_zv9", zv9, 0);
        chk("async_drop_zv10", zv10, 0);
        q9.delete();
        q10.delete();
        tick();
        CD = 1'b1;
        repeat (5) tick();
        chk("no_stale_zv9", zv9, 0);
        chk("no_stale_zv10", zv10, 0);
        lat_chk = 1'b1;
        set_in(1'b1, 9'h1FF, 10'h3FF, 1'b1);
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        repeat (5) tick();
        lat_chk = 1'b0;
        chk("post_reset_done9", q9.size(), 0);
        chk("post_reset_done10", q10.size(), 0);

        // Random valid/ready toggling
        repeat (10000) begin
            bit v;
            tick();
            v = ($urandom % 4) != 0;
            v9    = v;
            v10   = v;
            din9  = v ? rnd9()  : 'x;
            din10 = v ? rnd10() : 'x;
            zr9   = ($urandom % 3) != 0;
            zr10  = ($urandom % 3) != 0;
        end
        tick();
        set_in(1'b0, 'x, 'x, 1'b1);
        repeat (10) tick();
        @(negedge CP);
        chk("final_drain9", q9.size(), 0);
        chk("final_drain10", q10.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
